// File: rtl/uart_tx_pkg.sv
// UART TX shared definitions: line-state codes driven to the TX output mux
// and default widths for the frame controller.
package uart_tx_pkg;

    localparam int SEL_W          = 3;
    localparam int MUX_SEL_W_DEF  = SEL_W;
    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [SEL_W-1:0] state_t;

    // Line-state codes; the TX mux decodes these directly.
    localparam state_t IDLE   = 3'b000;
    localparam state_t START  = 3'b001;
    localparam state_t DATA   = 3'b010;
    localparam state_t PARITY = 3'b011;
    localparam state_t STOP   = 3'b100;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART TX payload serializer: LSB-first shift register plus bit counter.
// The controlling FSM owns load, clr and shift_en.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_data,
    output logic                  done
);

    // One extra count value so the counter never wraps inside a frame.
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    // Payload register: load on accept, shift right once per data bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= data;
        end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // Data-bit counter: cleared before the data phase, counts shifted bits.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (load || clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign ser_data = shift_reg[0];
    assign done     = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: sequences start, data, optional parity and stop,
// presenting the registered line-state code to the TX output mux.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MUX_SEL_W  = MUX_SEL_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [MUX_SEL_W-1:0]  mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    state_t state;
    state_t state_nxt;

    logic load;
    logic clr;
    logic shift_en;
    logic done;
    logic busy_nxt;
    logic par_nxt;
    logic par_en_q;

    // Even parity of the payload, inverted for odd parity.
    assign par_nxt = ^P_DATA ^ PAR_TYP;

    // State register; the state code is the mux select.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unused codes fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = Data_Valid ? START : IDLE;
            START:   state_nxt = DATA;
            DATA: begin
                if (!done) begin
                    state_nxt = DATA;
                end else if (par_en_q) begin
                    state_nxt = PARITY;
                end else begin
                    state_nxt = STOP;
                end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: serializer controls and next busy value per state.
    always_comb begin
        load     = 1'b0;
        clr      = 1'b0;
        shift_en = 1'b0;
        busy_nxt = 1'b0;
        case (state)
            IDLE: begin
                load     = Data_Valid;
                busy_nxt = Data_Valid;
            end
            START: begin
                clr      = 1'b1;
                busy_nxt = 1'b1;
            end
            DATA: begin
                shift_en = 1'b1;
                busy_nxt = 1'b1;
            end
            PARITY: begin
                busy_nxt = 1'b1;
            end
            STOP: begin
                busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Frame attributes captured with the payload, plus registered busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy     <= 1'b0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (load) begin
                par_bit  <= par_nxt;
                par_en_q <= PAR_EN;
            end
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .clr      (clr),
        .shift_en (shift_en),
        .data     (P_DATA),
        .ser_data (ser_data),
        .done     (done)
    );

    assign mux_sel = MUX_SEL_W'(state);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frames pushed to an expectation queue, a line
// monitor behind a model TX mux deserialises and compares each frame.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [2:0] mux_sel;
    logic       ser_data;
    logic       par_bit;
    logic       busy;
    logic       line;

    typedef struct packed {
        logic [7:0] data;
        logic       par_en;
        logic       par;
        logic       abort;
    } exp_t;

    exp_t exp_q[$];

    int nvec  = 0;
    int nfail = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (8),
        .MUX_SEL_W  (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model of the downstream TX mux driving the serial line.
    always_comb begin
        line = 1'b1;
        case (mux_sel)
            3'b000:  line = 1'b1;
            3'b001:  line = 1'b0;
            3'b010:  line = ser_data;
            3'b011:  line = par_bit;
            3'b100:  line = 1'b1;
            default: line = 1'b1;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor / scoreboard.
    exp_t       cur;
    logic       in_frame = 1'b0;
    int         idx;
    int         flen;
    logic       seq_ok;
    logic       busy_ok;
    logic [7:0] rx;
    logic       rxpar;
    logic       stopb;
    state_t     code;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (in_frame) begin
                    chk("abort_expected", int'(cur.abort), 1);
                    in_frame = 1'b0;
                end
            end else begin
                if (!in_frame && mux_sel == START) begin
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_frame: got start, expected none");
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        idx      = 0;
                        seq_ok   = 1'b1;
                        busy_ok  = 1'b1;
                        rx       = 8'h00;
                        rxpar    = 1'bx;
                        stopb    = 1'b0;
                    end
                end
                if (in_frame) begin
                    flen = cur.par_en ? 11 : 10;
                    if (idx < flen) begin
                        if (idx == 0)
                            code = START;
                        else if (idx <= 8)
                            code = DATA;
                        else if (idx == 9 && cur.par_en)
                            code = PARITY;
                        else
                            code = STOP;
                        if (mux_sel !== code) seq_ok = 1'b0;
                        if (busy !== 1'b1) busy_ok = 1'b0;
                        if (code == DATA) rx[idx-1] = line;
                        if (code == PARITY) rxpar = line;
                        if (code == STOP) stopb = line;
                        idx++;
                    end else begin
                        chk("state_seq", int'(seq_ok), 1);
                        chk("busy_frame", int'(busy_ok), 1);
                        chk("data_bits", int'(rx), int'(cur.data));
                        if (cur.par_en)
                            chk("parity_bit", int'(rxpar), int'(cur.par));
                        chk("stop_bit", int'(stopb), 1);
                        chk("idle_gap", int'(mux_sel), int'(IDLE));
                        chk("busy_low", int'(busy), 0);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one frame, scramble inputs mid-frame and poke ignored strobes.
    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input logic ep);
        int fl;
        fl = pe ? 11 : 10;
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        exp_q.push_back('{data: d, par_en: pe, par: ep, abort: 1'b0});
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        repeat (3) @(negedge CLK);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (fl - 5) @(negedge CLK);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        nfail++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       pe;
        logic       pt;

        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #3;
        chk("rst_mux_sel", int'(mux_sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ser_data", int'(ser_data), 0);
        chk("rst_par_bit", int'(par_bit), 0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;

        // Reset in the middle of the data phase of 0x3C.
        @(negedge CLK);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        exp_q.push_back('{data: 8'h3C, par_en: 1'b1, par: 1'b0, abort: 1'b1});
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort_mux_sel", int'(mux_sel), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst_idle", int'(mux_sel), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Directed frames: data, par_en, par_typ, hand-computed parity.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 1'b1);

        // Strobe held across a whole frame: second frame after one idle cycle.
        @(negedge CLK);
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        exp_q.push_back('{data: 8'h5A, par_en: 1'b1, par: 1'b0, abort: 1'b0});
        exp_q.push_back('{data: 8'hC3, par_en: 1'b0, par: 1'b1, abort: 1'b0});
        @(negedge CLK);
        P_DATA  = 8'hC3;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b1;
        repeat (12) @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = 8'hFF;
        repeat (12) @(negedge CLK);

        // Random frames.
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            send(d, pe, pt, ^d ^ pt);
        end

        repeat (3) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);
        chk("frame_closed", int'(in_frame), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
